menu_settings_ctrl: RTL and testbench

Button-driven settings editor for the traffic light controller. It turns the board's push-buttons into the settings state consumed by the on-screen text renderer and the light sequencer:
- the selected menu line;
- green duration, yellow duration and red-holding time, each in seconds, range 1–99.

Each button is synchronised and debounced. Increment and decrement auto-repeat while held. Every accepted value change produces a one-cycle notification pulse.

---
 rtl/menu_settings_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_menu_settings_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_settings_ctrl.sv
// Push-button settings editor: debounced navigation and duration editing
// with auto-repeat, feeding the renderer and the light sequencer.
module menu_settings_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000,
  parameter int unsigned VAL_MIN         = 1,
  parameter int unsigned VAL_MAX         = 99,
  parameter int unsigned GREEN_INIT      = 10,
  parameter int unsigned YELLOW_INIT     = 3,
  parameter int unsigned RED_INIT        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       edit_enable,
  output logic [3:0] menu_sel,
  output logic [7:0] green_duration,
  output logic [7:0] yellow_duration,
  output logic [7:0] red_holding,
  output logic       settings_changed
);

  localparam int unsigned DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [7:0] VMIN = 8'(VAL_MIN);
  localparam logic [7:0] VMAX = 8'(VAL_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_t;

  // Button order: 0 up, 1 down, 2 inc, 3 dec
  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]    stable_q, stable_d, prev_q, prev_d;
  logic [3:0]    press_q, press_d;
  logic [DW-1:0] cnt_q [4];
  logic [DW-1:0] cnt_d [4];

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          held_inc_q, held_inc_d;
  logic          rep_inc, rep_dec;

  logic [3:0]    menu_q, menu_d;
  logic [7:0]    green_q, green_d;
  logic [7:0]    yellow_q, yellow_d;
  logic [7:0]    red_q, red_d;
  logic          chg_q, chg_d;

  always_comb begin
    sync1_d = {btn_dec, btn_inc, btn_down, btn_up};
    sync2_d = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1))
          stable_d[i] = ~stable_q[i];
        else
          cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
    prev_d  = stable_q;
    press_d = stable_q & ~prev_q;
  end

  logic held_lvl, both_held;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    held_inc_d = held_inc_q;
    rep_inc    = 1'b0;
    rep_dec    = 1'b0;
    held_lvl   = held_inc_q ? stable_q[2] : stable_q[3];
    both_held  = stable_q[2] & stable_q[3];
    case (state_q)
      S_IDLE: begin
        if (edit_enable && (press_q[2] || press_q[3]) &&
            (stable_q[2] ^ stable_q[3])) begin
          state_d    = S_DELAY;
          timer_d    = '0;
          held_inc_d = stable_q[2];
        end
      end
      S_DELAY, S_REPEAT: begin
        // Release, chord or edit lock cancels the hold outright
        if (!edit_enable || !held_lvl || both_held) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if ((state_q == S_DELAY &&
                      timer_q == TW'(REPEAT_DELAY - 1)) ||
                     (state_q == S_REPEAT &&
                      timer_q == TW'(REPEAT_PERIOD - 1))) begin
          state_d = S_REPEAT;
          timer_d = '0;
          rep_inc = held_inc_q;
          rep_dec = ~held_inc_q;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  logic       inc_ev, dec_ev;
  logic [7:0] cur_val, new_val;

  always_comb begin
    menu_d   = menu_q;
    green_d  = green_q;
    yellow_d = yellow_q;
    red_d    = red_q;
    inc_ev   = press_q[2] | rep_inc;
    dec_ev   = press_q[3] | rep_dec;
    case (menu_q)
      4'd2:    cur_val = yellow_q;
      4'd3:    cur_val = red_q;
      default: cur_val = green_q;
    endcase
    new_val = cur_val;
    if (edit_enable) begin
      if (press_q[0] || press_q[1]) begin
        if (press_q[0] && !press_q[1])
          menu_d = (menu_q == 4'd1) ? 4'd3 : menu_q - 4'd1;
        else if (press_q[1] && !press_q[0])
          menu_d = (menu_q == 4'd3) ? 4'd1 : menu_q + 4'd1;
      end else if (inc_ev && !dec_ev) begin
        new_val = (cur_val >= VMAX) ? VMAX : cur_val + 8'd1;
      end else if (dec_ev && !inc_ev) begin
        new_val = (cur_val <= VMIN) ? VMIN : cur_val - 8'd1;
      end
    end
    case (menu_q)
      4'd2:    yellow_d = new_val;
      4'd3:    red_d    = new_val;
      default: green_d  = new_val;
    endcase
    chg_d = (green_d != green_q) || (yellow_d != yellow_q) ||
            (red_d != red_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      prev_q     <= '0;
      press_q    <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      state_q    <= S_IDLE;
      timer_q    <= '0;
      held_inc_q <= 1'b0;
      menu_q     <= 4'd1;
      green_q    <= 8'(GREEN_INIT);
      yellow_q   <= 8'(YELLOW_INIT);
      red_q      <= 8'(RED_INIT);
      chg_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      prev_q     <= prev_d;
      press_q    <= press_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      state_q    <= state_d;
      timer_q    <= timer_d;
      held_inc_q <= held_inc_d;
      menu_q     <= menu_d;
      green_q    <= green_d;
      yellow_q   <= yellow_d;
      red_q      <= red_d;
      chg_q      <= chg_d;
    end
  end

  assign menu_sel         = menu_q;
  assign green_duration   = green_q;
  assign yellow_duration  = yellow_q;
  assign red_holding      = red_q;
  assign settings_changed = chg_q;

endmodule

// File: tb/tb_menu_settings_ctrl.sv
// Bench for menu_settings_ctrl: directed vector table, hold/reset
// sequences and random buttons against a cycle-level reference model.
module tb_menu_settings_ctrl;

  localparam int DB   = 4;
  localparam int RD   = 20;
  localparam int RP   = 5;
  localparam int VMIN = 1;
  localparam int VMAX = 99;

  logic       clk = 0;
  logic       rst = 1;
  logic       btn_up = 0, btn_down = 0, btn_inc = 0, btn_dec = 0;
  logic       edit_enable = 1;
  logic [3:0] menu_sel;
  logic [7:0] green_duration, yellow_duration, red_holding;
  logic       settings_changed;

  always #5 clk = ~clk;

  menu_settings_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .VAL_MIN(VMIN),
    .VAL_MAX(VMAX),
    .GREEN_INIT(10),
    .YELLOW_INIT(3),
    .RED_INIT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .edit_enable(edit_enable),
    .menu_sel(menu_sel),
    .green_duration(green_duration),
    .yellow_duration(yellow_duration),
    .red_holding(red_holding),
    .settings_changed(settings_changed)
  );

  // Reference model: a button level is accepted once the last DB
  // synchronised samples all disagree with it; events follow by a
  // fixed two-edge pipeline; repeats are timed from the press edge.
  logic [DB+1:0] m_hist [4];
  logic [3:0]    m_st, m_p1, m_p2;
  bit            m_act, m_hinc, m_chg, m_valid;
  int            m_k0, m_cyc, m_menu;
  int            m_val [3];

  always @(posedge clk) begin : model
    logic [3:0] raw, press, cur;
    bit         rinc, rdec, inc, dec;
    int         old, nv, idx, age;
    raw = {btn_dec, btn_inc, btn_down, btn_up};
    m_cyc++;
    if (rst) begin
      for (int b = 0; b < 4; b++) m_hist[b] = '0;
      m_st = '0; m_p1 = '0; m_p2 = '0;
      m_act = 0; m_hinc = 0; m_chg = 0;
      m_menu = 1; m_val = '{10, 3, 2};
      m_valid = 1;
    end else begin
      press = m_p1 & ~m_p2;
      cur = m_st;
      rinc = 0; rdec = 0;
      if (m_act) begin
        if (!edit_enable || !(m_hinc ? cur[2] : cur[3]) ||
            (cur[2] && cur[3])) begin
          m_act = 0;
        end else begin
          age = m_cyc - m_k0;
          if (age >= RD && (age - RD) % RP == 0) begin
            rinc = m_hinc; rdec = !m_hinc;
          end
        end
      end else if (edit_enable && (press[2] || press[3]) &&
                   (cur[2] != cur[3])) begin
        m_act = 1; m_k0 = m_cyc; m_hinc = cur[2];
      end
      idx = m_menu - 1;
      old = m_val[idx];
      nv = old;
      inc = press[2] || rinc;
      dec = press[3] || rdec;
      if (edit_enable) begin
        if (press[0] || press[1]) begin
          if (press[0] && !press[1]) m_menu = (m_menu + 1) % 3 + 1;
          else if (press[1] && !press[0]) m_menu = m_menu % 3 + 1;
        end else if (inc != dec) begin
          if (inc) nv = (old + 1 > VMAX) ? VMAX : old + 1;
          else     nv = (old - 1 < VMIN) ? VMIN : old - 1;
        end
      end
      m_val[idx] = nv;
      m_chg = (nv != old);
      m_p2 = m_p1;
      m_p1 = m_st;
      for (int b = 0; b < 4; b++) begin
        m_hist[b] = {m_hist[b][DB:0], raw[b]};
        if (m_hist[b][DB+1:2] == {DB{~m_st[b]}}) m_st[b] = ~m_st[b];
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (settings_changed === 1'b1) pulses++;
    if (m_valid) begin
      checks++;
      if (menu_sel !== 4'(m_menu) ||
          green_duration !== 8'(m_val[0]) ||
          yellow_duration !== 8'(m_val[1]) ||
          red_holding !== 8'(m_val[2]) ||
          settings_changed !== m_chg) begin
        errors++;
        $display("FAIL model t=%0t: got m=%0d g=%0d y=%0d r=%0d c=%0b exp m=%0d g=%0d y=%0d r=%0d c=%0b",
                 $time, menu_sel, green_duration, yellow_duration,
                 red_holding, settings_changed, m_menu, m_val[0],
                 m_val[1], m_val[2], m_chg);
      end
    end
  endtask

  task automatic set_btns(input logic [3:0] b);
    {btn_dec, btn_inc, btn_down, btn_up} = b;
  endtask

  task automatic check_all(input string tag, input int m, input int g,
                           input int y, input int r);
    check({tag, " menu"}, menu_sel, m);
    check({tag, " green"}, green_duration, g);
    check({tag, " yellow"}, yellow_duration, y);
    check({tag, " red"}, red_holding, r);
  endtask

  typedef struct {
    logic [3:0] btn;
    int         hold;
    bit         en;
    int         menu;
    int         g;
    int         y;
    int         r;
    int         pulses;
  } vec_t;

  vec_t vecs [14];

  initial begin
    // btn bits: 0 up, 1 down, 2 inc, 3 dec
    vecs = '{
      '{4'b0100, 10,  1, 1, 11, 3, 2,  1},
      '{4'b0001, 10,  1, 3, 11, 3, 2,  0},
      '{4'b0010, 10,  1, 1, 11, 3, 2,  0},
      '{4'b0010, 10,  1, 2, 11, 3, 2,  0},
      '{4'b1000, 10,  1, 2, 11, 2, 2,  1},
      '{4'b1000, 10,  1, 2, 11, 1, 2,  1},
      '{4'b1000, 10,  1, 2, 11, 1, 2,  0},
      '{4'b0010, 3,   1, 2, 11, 1, 2,  0},
      '{4'b1100, 10,  1, 2, 11, 1, 2,  0},
      '{4'b0100, 10,  0, 2, 11, 1, 2,  0},
      '{4'b0010, 10,  1, 3, 11, 1, 2,  0},
      '{4'b0100, 700, 1, 3, 11, 1, 99, 97},
      '{4'b1000, 10,  1, 3, 11, 1, 98, 1},
      '{4'b1000, 10,  1, 3, 11, 1, 97, 1}
    };

    rst = 1;
    repeat (3) step();
    check_all("reset", 1, 10, 3, 2);
    check("reset changed", settings_changed, 0);
    rst = 0;
    repeat (2) step();

    for (int i = 0; i < 14; i++) begin
      edit_enable = vecs[i].en;
      set_btns(vecs[i].btn);
      pulses = 0;
      repeat (vecs[i].hold) step();
      set_btns(4'b0000);
      repeat (15) step();
      edit_enable = 1;
      check_all($sformatf("vec%0d", i), vecs[i].menu, vecs[i].g,
                vecs[i].y, vecs[i].r);
      check($sformatf("vec%0d pulses", i), pulses, vecs[i].pulses);
    end

    // Hold inc on red from 97: step at press, step after RD, then saturate
    btn_inc = 1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (i == 7)  check("hold pre-press", red_holding, 97);
      if (i == 8) begin
        check("hold press", red_holding, 98);
        check("hold press pulse", settings_changed, 1);
      end
      if (i == 9)  check("hold pulse width", settings_changed, 0);
      if (i == 27) check("hold pre-repeat", red_holding, 98);
      if (i == 28) begin
        check("hold repeat", red_holding, 99);
        check("hold repeat pulse", settings_changed, 1);
        pulses = 0;
      end
    end
    check("hold saturated pulses", pulses, 0);
    btn_inc = 0;
    repeat (15) step();
    check("hold final", red_holding, 99);

    // Reset mid-repeat with the button still held
    btn_inc = 1;
    repeat (40) step();
    rst = 1;
    step();
    check_all("mid rst", 1, 10, 3, 2);
    check("mid rst changed", settings_changed, 0);
    rst = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 7)  check("post rst pre", green_duration, 10);
      if (i == 8)  check("post rst press", green_duration, 11);
      if (i == 27) check("post rst pre-repeat", green_duration, 11);
      if (i == 28) check("post rst repeat", green_duration, 12);
    end
    btn_inc = 0;
    repeat (15) step();

    // Random buttons against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 11) == 0) btn_up   = ~btn_up;
      if ($urandom_range(0, 11) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 9) == 0)  btn_inc  = ~btn_inc;
      if ($urandom_range(0, 9) == 0)  btn_dec  = ~btn_dec;
      if ($urandom_range(0, 199) == 0) edit_enable = ~edit_enable;
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 0;
    edit_enable = 1;
    set_btns(4'b0000);
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
